// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - load/store unit converting CPU byte/half/word accesses into dmem word accesses
//
// Purpose: accepts one load or store at a time over a valid/ready channel and turns it
// into word accesses on dmem. Sub-word stores read the word first and write back a merged
// word. Loads are sign- or zero-extended. Illegal requests respond with an error and make
// no memory access.
//
// Ports:
//   clk, reset                  clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready         request handshake; ready only while idle
//   req_we, req_size,           store flag, size (00 byte, 01 half, 10 word, 11 illegal),
//   req_unsigned, req_addr,     zero-extend flag, byte address,
//   req_wdata                   right-aligned store data
//   rsp_valid, rsp_rdata,       one-cycle response pulse, extended load data,
//   rsp_err                     error flag (misaligned, out of range, illegal size)
//   mem_a, mem_we, mem_wd       dmem word address, write enable, write data
//   mem_rd                      dmem combinational read data
module mem_lsu #(
  parameter int DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_a,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  state_t      r_state;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata;

  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic [31:0] r_mem_a;
  logic        r_mem_we;
  logic [31:0] r_mem_wd;

  logic        w_req_err;
  logic [31:0] w_merge;
  logic [31:0] w_load;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign mem_a     = r_mem_a;
  assign mem_we    = r_mem_we;
  assign mem_wd    = r_mem_wd;

  // Request legality is judged on the live inputs at the accept edge.
  always_comb begin
    w_req_err = 1'b0;
    if (req_size == 2'b11) w_req_err = 1'b1;
    if (req_size == 2'b01 && req_addr[0]) w_req_err = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00) w_req_err = 1'b1;
    if (req_addr[31:2] >= 30'(DEPTH_WORDS)) w_req_err = 1'b1;
  end

  // Sub-word store: replace only the addressed lane(s) of the word read back from dmem.
  always_comb begin
    w_merge = mem_rd;
    if (r_size == 2'b00) w_merge[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
    else                 w_merge[{r_lane[1], 4'b0000} +: 16] = r_wdata;
  end

  always_comb begin
    w_byte = mem_rd[{r_lane, 3'b000} +: 8];
    w_half = mem_rd[{r_lane[1], 4'b0000} +: 16];
    case (r_size)
      2'b00:   w_load = r_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load = r_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load = mem_rd;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_size      <= 2'b00;
      r_unsigned  <= 1'b0;
      r_lane      <= 2'b00;
      r_wdata     <= 16'h0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
      r_mem_a     <= 32'h0;
      r_mem_we    <= 1'b0;
      r_mem_wd    <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_we        <= req_we;
            r_size      <= req_size;
            r_unsigned  <= req_unsigned;
            r_lane      <= req_addr[1:0];
            r_wdata     <= req_wdata[15:0];
            r_req_ready <= 1'b0;
            if (w_req_err) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= 32'h0;
            end else if (req_we && req_size == 2'b10) begin
              // Full-word store needs no read; go straight to the write.
              r_state  <= S_WRITE;
              r_mem_a  <= {req_addr[31:2], 2'b00};
              r_mem_we <= 1'b1;
              r_mem_wd <= req_wdata;
            end else begin
              r_state <= S_READ;
              r_mem_a <= {req_addr[31:2], 2'b00};
            end
          end
        end
        S_READ: begin
          if (r_we) begin
            r_state  <= S_WRITE;
            r_mem_we <= 1'b1;
            r_mem_wd <= w_merge;
          end else begin
            r_state     <= S_RESP;
            r_mem_a     <= 32'h0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= w_load;
          end
        end
        S_WRITE: begin
          // dmem commits the write at this edge.
          r_state     <= S_RESP;
          r_mem_we    <= 1'b0;
          r_mem_wd    <= 32'h0;
          r_mem_a     <= 32'h0;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= 32'h0;
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - self-checking bench for mem_lsu
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_a;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [0:63];

  int n_vec = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_lsu #(.DEPTH_WORDS(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // dmem model: combinational read, write on the rising edge.
  assign mem_rd = mem[mem_a[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_a[7:2]] = mem_wd;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] e_rd;
    logic        e_err;
    int          e_lat;
    int          e_we;
    logic [31:0] e_wd;
  } vec_t;

  vec_t vecs [22];

  function automatic vec_t mk(string n, logic we, logic [1:0] sz, logic uns,
                              logic [31:0] a, logic [31:0] wd, logic [31:0] erd,
                              logic eerr, int elat, int ewe, logic [31:0] ewd);
    vec_t v;
    v.name = n; v.we = we; v.sz = sz; v.uns = uns; v.addr = a; v.wd = wd;
    v.e_rd = erd; v.e_err = eerr; v.e_lat = elat; v.e_we = ewe; v.e_wd = ewd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request starting from a falling edge with the LSU idle; returns at a falling edge.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output int we_cnt, output logic [31:0] wd_seen,
                        output logic [31:0] a_seen, output logic pulse_ok);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; we_cnt = 0; wd_seen = 32'h0; a_seen = 32'h0; rdata = 32'h0; err = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (mem_we) begin
        we_cnt++;
        wd_seen = mem_wd;
        a_seen = mem_a;
      end
      if (rsp_valid) begin
        lat = n;
        rdata = rsp_rdata;
        err = rsp_err;
        break;
      end
    end
    @(negedge clk);
    pulse_ok = !rsp_valid && req_ready;
  endtask

  initial begin
    int lat;
    int we_cnt;
    logic [31:0] rdata;
    logic [31:0] wd_seen;
    logic [31:0] a_seen;
    logic err;
    logic pulse_ok;

    vecs[0]  = mk("st_w_10",   1, 2'b10, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0, 2, 1, 32'hDEADBEEF);
    vecs[1]  = mk("ld_w_10",   0, 2'b10, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0, 2, 0, 32'h0);
    vecs[2]  = mk("st_b_21",   1, 2'b00, 0, 32'h21,  32'h555555AA, 32'h0,        0, 3, 1, 32'h1122AA44);
    vecs[3]  = mk("ld_bs_21",  0, 2'b00, 0, 32'h21,  32'h0,        32'hFFFFFFAA, 0, 2, 0, 32'h0);
    vecs[4]  = mk("ld_bu_21",  0, 2'b00, 1, 32'h21,  32'h0,        32'h000000AA, 0, 2, 0, 32'h0);
    vecs[5]  = mk("ld_bs_20",  0, 2'b00, 0, 32'h20,  32'h0,        32'h00000044, 0, 2, 0, 32'h0);
    vecs[6]  = mk("ld_hs_32",  0, 2'b01, 0, 32'h32,  32'h0,        32'hFFFF8001, 0, 2, 0, 32'h0);
    vecs[7]  = mk("ld_hs_30",  0, 2'b01, 0, 32'h30,  32'h0,        32'h00007FFF, 0, 2, 0, 32'h0);
    vecs[8]  = mk("ld_hu_32",  0, 2'b01, 1, 32'h32,  32'h0,        32'h00008001, 0, 2, 0, 32'h0);
    vecs[9]  = mk("st_h_32",   1, 2'b01, 0, 32'h32,  32'hABCD1234, 32'h0,        0, 3, 1, 32'h12347FFF);
    vecs[10] = mk("ld_w_30",   0, 2'b10, 0, 32'h30,  32'h0,        32'h12347FFF, 0, 2, 0, 32'h0);
    vecs[11] = mk("ld_wu_10",  0, 2'b10, 1, 32'h10,  32'h0,        32'hDEADBEEF, 0, 2, 0, 32'h0);
    vecs[12] = mk("err_h_13",  0, 2'b01, 0, 32'h13,  32'h0,        32'h0,        1, 1, 0, 32'h0);
    vecs[13] = mk("err_sw_22", 1, 2'b10, 0, 32'h22,  32'hFFFFFFFF, 32'h0,        1, 1, 0, 32'h0);
    vecs[14] = mk("err_sz11",  0, 2'b11, 0, 32'h40,  32'h0,        32'h0,        1, 1, 0, 32'h0);
    vecs[15] = mk("err_w_100", 0, 2'b10, 0, 32'h100, 32'h0,        32'h0,        1, 1, 0, 32'h0);
    vecs[16] = mk("st_w_fc",   1, 2'b10, 0, 32'hFC,  32'hCAFEF00D, 32'h0,        0, 2, 1, 32'hCAFEF00D);
    vecs[17] = mk("ld_w_fc",   0, 2'b10, 0, 32'hFC,  32'h0,        32'hCAFEF00D, 0, 2, 0, 32'h0);
    vecs[18] = mk("st_b_23",   1, 2'b00, 0, 32'h23,  32'h00000099, 32'h0,        0, 3, 1, 32'h9922AA44);
    vecs[19] = mk("ld_bs_23",  0, 2'b00, 0, 32'h23,  32'h0,        32'hFFFFFF99, 0, 2, 0, 32'h0);
    vecs[20] = mk("err_sb_104",1, 2'b00, 0, 32'h104, 32'h000000EE, 32'h0,        1, 1, 0, 32'h0);
    vecs[21] = mk("ld_hu_22",  0, 2'b01, 1, 32'h22,  32'h0,        32'h00009922, 0, 2, 0, 32'h0);

    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[8]  = 32'h11223344;
    mem[12] = 32'h80017FFF;

    #2 reset = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err",   {31'h0, rsp_err}, 32'h0);
    chk("rst_mem_a",     mem_a, 32'h0);
    chk("rst_mem_we",    {31'h0, mem_we}, 32'h0);
    chk("rst_mem_wd",    mem_wd, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);

    for (int i = 0; i < 22; i++) begin
      do_req(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd,
             lat, rdata, err, we_cnt, wd_seen, a_seen, pulse_ok);
      chk({vecs[i].name, "_lat"},   lat, vecs[i].e_lat);
      chk({vecs[i].name, "_rdata"}, rdata, vecs[i].e_rd);
      chk({vecs[i].name, "_err"},   {31'h0, err}, {31'h0, vecs[i].e_err});
      chk({vecs[i].name, "_wecnt"}, we_cnt, vecs[i].e_we);
      chk({vecs[i].name, "_pulse"}, {31'h0, pulse_ok}, 32'h1);
      if (vecs[i].e_we != 0) begin
        chk({vecs[i].name, "_wd"}, wd_seen, vecs[i].e_wd);
        chk({vecs[i].name, "_a"},  a_seen, {vecs[i].addr[31:2], 2'b00});
      end
    end
    chk("mem_word8",  mem[8],  32'h9922AA44);
    chk("mem_word4",  mem[4],  32'hDEADBEEF);
    chk("mem_word12", mem[12], 32'h12347FFF);
    chk("mem_word63", mem[63], 32'hCAFEF00D);
    chk("mem_word16", mem[16], 32'h0);

    // Handshake: req_valid held high; each word load takes accept, READ, RESP.
    req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10;
    req_valid = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      chk($sformatf("hs_ready_%0d", n), {31'h0, req_ready}, (n % 3 == 0) ? 32'h1 : 32'h0);
      chk($sformatf("hs_rv_%0d", n),    {31'h0, rsp_valid}, (n % 3 == 2) ? 32'h1 : 32'h0);
      if (n % 3 == 2) chk($sformatf("hs_rdata_%0d", n), rsp_rdata, 32'hDEADBEEF);
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("hs_idle_ready", {31'h0, req_ready}, 32'h1);
    chk("hs_idle_rv",    {31'h0, rsp_valid}, 32'h0);

    // Reset during the WRITE cycle of a byte store.
    req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h20;
    req_wdata = 32'h00000055; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rmo_read_we", {31'h0, mem_we}, 32'h0);
    @(posedge clk);
    #2;
    chk("rmo_write_we", {31'h0, mem_we}, 32'h1);
    chk("rmo_write_wd", mem_wd, 32'h9922AA55);
    reset = 1'b0;
    #1;
    chk("rmo_we",        {31'h0, mem_we}, 32'h0);
    chk("rmo_wd",        mem_wd, 32'h0);
    chk("rmo_a",         mem_a, 32'h0);
    chk("rmo_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rmo_rsp_rdata", rsp_rdata, 32'h0);
    chk("rmo_rsp_err",   {31'h0, rsp_err}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rmo_mem_word8", mem[8], 32'h9922AA44);
    reset = 1'b1;
    @(negedge clk);
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, rdata, err, we_cnt, wd_seen, a_seen, pulse_ok);
    chk("post_rst_lat",   lat, 2);
    chk("post_rst_rdata", rdata, 32'h9922AA44);
    chk("post_rst_err",   {31'h0, err}, 32'h0);
    chk("post_rst_pulse", {31'h0, pulse_ok}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
